// File: rtl/merge2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : merge2_arbiter
//  Description : Round-robin 2:1 packet merge; emits grant id on G, then the
//                packet on Out, with saturating per-input accept counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module merge2_arbiter #(
    parameter int DATA_W = 9,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              g_valid,
    output logic              g_data,
    input  logic              g_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND_G   = 2'd1,
        S_SEND_OUT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic              r_prio;
    logic              r_win;
    logic              r_g_valid;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_pkt;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_sel;
    logic              w_accept;

    // A lone requester wins regardless of prio; prio only breaks ties.
    always_comb begin
        w_sel    = (in0_valid && in1_valid) ? r_prio : in1_valid;
        w_accept = (r_state == S_IDLE) && (in0_valid || in1_valid);
    end

    assign in0_ready = w_accept && !w_sel;
    assign in1_ready = w_accept &&  w_sel;

    assign g_valid   = r_g_valid;
    assign g_data    = r_win;
    assign out_valid = r_out_valid;
    assign out_data  = r_pkt;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_prio      <= 1'b0;
            r_win       <= 1'b0;
            r_g_valid   <= 1'b0;
            r_out_valid <= 1'b0;
            r_pkt       <= '0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pkt     <= w_sel ? in1_data : in0_data;
                        r_win     <= w_sel;
                        r_g_valid <= 1'b1;
                        r_state   <= S_SEND_G;
                        if (!w_sel && (r_cnt0 != c_cnt_max))
                            r_cnt0 <= r_cnt0 + c_cnt_one;
                        if (w_sel && (r_cnt1 != c_cnt_max))
                            r_cnt1 <= r_cnt1 + c_cnt_one;
                    end
                end
                S_SEND_G: begin
                    if (g_ready) begin
                        r_g_valid   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_SEND_OUT;
                    end
                end
                S_SEND_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_prio      <= ~r_win;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_g_valid   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_merge2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_merge2_arbiter
//  Description : Directed self-checking bench for merge2_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_merge2_arbiter;

    localparam int DATA_W = 9;
    localparam int CNT_W  = 8;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              in0_valid, in1_valid, in0_ready, in1_ready;
    logic [DATA_W-1:0] in0_data, in1_data, out_data;
    logic              g_valid, g_data, g_ready, out_valid, out_ready;
    logic [CNT_W-1:0]  cnt0, cnt1;

    // Second instance with a narrow counter for the saturation test
    logic              s_in0_valid, s_in0_ready, s_in1_ready;
    logic [DATA_W-1:0] s_in0_data, s_out_data;
    logic              s_g_valid, s_g_data, s_out_valid;
    logic [1:0]        s_cnt0, s_cnt1;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    bit seen_0f0 = 1'b0;

    always #5 CLK = ~CLK;

    merge2_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .g_valid(g_valid), .g_data(g_data), .g_ready(g_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    merge2_arbiter #(.DATA_W(DATA_W), .CNT_W(2)) dut2 (
        .CLK(CLK), .RESET(RESET),
        .in0_valid(s_in0_valid), .in0_data(s_in0_data), .in0_ready(s_in0_ready),
        .in1_valid(1'b0), .in1_data('0), .in1_ready(s_in1_ready),
        .g_valid(s_g_valid), .g_data(s_g_data), .g_ready(1'b1),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(1'b1),
        .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    always @(posedge CLK) begin
        if (out_valid && out_ready) begin
            n_out = n_out + 1;
            if (out_data == 9'h0F0) seen_0f0 = 1'b1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        in0_valid = 0; in1_valid = 0; in0_data = '0; in1_data = '0;
        g_ready = 0; out_ready = 0;
        s_in0_valid = 0; s_in0_data = '0;
        do_reset();
        total++; if (g_valid !== 1'b0) begin bad++; $display("FAIL rst_g_valid got=%b exp=0", g_valid); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if ({in0_ready, in1_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", {in0_ready, in1_ready}); end
        total++; if ({cnt0, cnt1} !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=0000", {cnt0, cnt1}); end
        total++; if ({g_data, out_data} !== 10'h0) begin bad++; $display("FAIL rst_data got=%h exp=000", {g_data, out_data}); end
    endtask

    task automatic test_single();
        in0_valid = 1; in0_data = 9'h1A5; g_ready = 1; out_ready = 1;
        #1;
        total++; if ({in0_ready, in1_ready} !== 2'b10) begin bad++; $display("FAIL t1_ready got=%b exp=10", {in0_ready, in1_ready}); end
        tick();
        in0_valid = 0;
        total++; if ({g_valid, g_data} !== 2'b10) begin bad++; $display("FAIL t1_grant got=%b exp=10", {g_valid, g_data}); end
        total++; if (cnt0 !== 8'd1) begin bad++; $display("FAIL t1_cnt0 got=%0d exp=1", cnt0); end
        tick();
        total++; if ({out_valid, out_data} !== {1'b1, 9'h1A5}) begin bad++; $display("FAIL t1_out got=%b/%h exp=1/1a5", out_valid, out_data); end
        total++; if (g_valid !== 1'b0) begin bad++; $display("FAIL t1_g_drop got=%b exp=0", g_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_out_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [DATA_W-1:0] exp_d;
        do_reset();
        in0_valid = 1; in0_data = 9'h011; in1_valid = 1; in1_data = 9'h122;
        g_ready = 1; out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 1) ? 9'h122 : 9'h011;
            #1;
            total++; if ({in0_ready, in1_ready} !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL t2_ready k=%0d got=%b", k, {in0_ready, in1_ready}); end
            tick();
            total++; if ({g_valid, g_data} !== {1'b1, k[0]}) begin bad++; $display("FAIL t2_grant k=%0d got=%b exp=1%b", k, {g_valid, g_data}, k[0]); end
            total++; if ({in0_ready, in1_ready} !== 2'b00) begin bad++; $display("FAIL t2_busy k=%0d got=%b exp=00", k, {in0_ready, in1_ready}); end
            tick();
            total++; if ({out_valid, out_data} !== {1'b1, exp_d}) begin bad++; $display("FAIL t2_out k=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, exp_d); end
            tick();
        end
        in0_valid = 0; in1_valid = 0;
        total++; if ({cnt0, cnt1} !== {8'd2, 8'd2}) begin bad++; $display("FAIL t2_cnt got=%0d/%0d exp=2/2", cnt0, cnt1); end
    endtask

    task automatic test_backpressure();
        int n0;
        do_reset();
        in0_valid = 1; in0_data = 9'h055; g_ready = 0; out_ready = 0;
        n0 = n_out;
        tick();
        in1_valid = 1; in1_data = 9'h0AA;
        for (int c = 0; c < 5; c++) begin
            total++; if ({g_valid, g_data, out_valid, in0_ready, in1_ready} !== 5'b10000) begin bad++; $display("FAIL t3_g_hold c=%0d got=%b exp=10000", c, {g_valid, g_data, out_valid, in0_ready, in1_ready}); end
            tick();
        end
        g_ready = 1;
        tick();
        g_ready = 0;
        for (int c = 0; c < 3; c++) begin
            total++; if ({out_valid, out_data, g_valid, in0_ready, in1_ready} !== {1'b1, 9'h055, 3'b000}) begin bad++; $display("FAIL t3_out_hold c=%0d got=%b/%h exp=1/055", c, out_valid, out_data); end
            tick();
        end
        in0_valid = 0; in1_valid = 0; out_ready = 1;
        tick();
        total++; if (n_out - n0 !== 1) begin bad++; $display("FAIL t3_nout got=%0d exp=1", n_out - n0); end
        total++; if ({cnt0, cnt1} !== {8'd1, 8'd0}) begin bad++; $display("FAIL t3_cnt got=%0d/%0d exp=1/0", cnt0, cnt1); end
    endtask

    task automatic test_lone_in1();
        do_reset();
        g_ready = 1; out_ready = 1;
        // one In0 packet leaves prio=1
        in0_valid = 1; in0_data = 9'h003;
        tick(); in0_valid = 0; tick(); tick();
        for (int r = 0; r < 2; r++) begin
            in1_valid = 1; in1_data = 9'h1E3;
            #1;
            total++; if ({in0_ready, in1_ready} !== 2'b01) begin bad++; $display("FAIL t4_ready r=%0d got=%b exp=01", r, {in0_ready, in1_ready}); end
            tick();
            in1_valid = 0;
            total++; if ({g_valid, g_data} !== 2'b11) begin bad++; $display("FAIL t4_grant r=%0d got=%b exp=11", r, {g_valid, g_data}); end
            tick();
            total++; if (out_data !== 9'h1E3) begin bad++; $display("FAIL t4_out r=%0d got=%h exp=1e3", r, out_data); end
            tick();
        end
        total++; if (cnt1 !== 8'd2) begin bad++; $display("FAIL t4_cnt1 got=%0d exp=2", cnt1); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        g_ready = 1; out_ready = 0;
        in0_valid = 1; in0_data = 9'h0F0;
        tick(); in0_valid = 0; tick();
        total++; if ({out_valid, out_data} !== {1'b1, 9'h0F0}) begin bad++; $display("FAIL t5_pre got=%b/%h exp=1/0f0", out_valid, out_data); end
        RESET = 1;
        tick();
        RESET = 0;
        total++; if ({out_valid, g_valid, out_data} !== 11'h0) begin bad++; $display("FAIL t5_flush got=%b%b/%h exp=00/000", out_valid, g_valid, out_data); end
        total++; if ({cnt0, cnt1} !== 16'h0) begin bad++; $display("FAIL t5_cnt got=%h exp=0000", {cnt0, cnt1}); end
        out_ready = 1;
        tick(); tick(); tick();
        total++; if ({out_valid, seen_0f0} !== 2'b00) begin bad++; $display("FAIL t5_never got=%b%b exp=00", out_valid, seen_0f0); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c [5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int p = 0; p < 5; p++) begin
            s_in0_valid = 1; s_in0_data = 9'(p);
            tick();
            s_in0_valid = 0;
            total++; if (s_cnt0 !== exp_c[p]) begin bad++; $display("FAIL t6_cnt p=%0d got=%0d exp=%0d", p, s_cnt0, exp_c[p]); end
            tick();
            tick();
        end
        total++; if (s_cnt1 !== 2'd0) begin bad++; $display("FAIL t6_cnt1 got=%0d exp=0", s_cnt1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lone_in1();
        test_reset_mid_packet();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
